pin_pattern_drv: RTL

Parametrised multi-channel output-pin driver for the ICE40 stream/debug builds. It is the generalisation of the fixed two-pin, constant-level registered-output debug top. Each channel holds a registered output level and an output enable, and runs one of four modes: hold, toggle, shift a word MSB-first, or hi-Z. A valid/ready command port allows gapless back-to-back shift words per channel. It sits between debug/stream control logic and the top-level SB_IO output registers.

---
 rtl/pin_pattern_drv.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/pin_pattern_drv.sv
// Multi-channel registered pin driver: per-channel HOLD / TOGGLE / SHIFT (MSB first) / HIZ.
// Latency: an accepted command is visible on pin_out/pin_oe right after the accepting edge.
// Backpressure: cmd_ready drops only while the addressed channel still has bits left to shift.
module pin_pattern_drv #(
    parameter int CHANNELS = 2,
    parameter int WIDTH    = 16
) (
    input  logic                                                clk,
    input  logic                                                rst,
    input  logic                                                cmd_valid,
    output logic                                                cmd_ready,
    input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] cmd_chan,
    input  logic [1:0]                                          cmd_mode,
    input  logic [WIDTH-1:0]                                    cmd_data,
    output logic [CHANNELS-1:0]                                 pin_out,
    output logic [CHANNELS-1:0]                                 pin_oe,
    output logic [CHANNELS-1:0]                                 busy,
    output logic [CHANNELS-1:0]                                 done
);

    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int NW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        M_HOLD   = 2'd0,
        M_TOGGLE = 2'd1,
        M_SHIFT  = 2'd2,
        M_HIZ    = 2'd3
    } mode_t;

    mode_t               mode_q  [CHANNELS];
    mode_t               mode_d  [CHANNELS];
    logic [WIDTH-1:0]    shreg_q [CHANNELS];
    logic [WIDTH-1:0]    shreg_d [CHANNELS];
    logic [NW-1:0]       cnt_q   [CHANNELS];
    logic [NW-1:0]       cnt_d   [CHANNELS];
    logic [CHANNELS-1:0] pin_q, pin_d;
    logic [CHANNELS-1:0] oe_q, oe_d;
    logic [CHANNELS-1:0] busy_q, busy_d;
    logic [CHANNELS-1:0] done_q, done_d;
    logic [CHANNELS-1:0] hit;
    logic [CHANNELS-1:0] accept;

    // Out-of-range channels match no slot, so ready stays 1 and the command is dropped.
    always_comb begin
        cmd_ready = 1'b1;
        hit       = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (cmd_chan == CW'(c)) begin
                hit[c]    = 1'b1;
                cmd_ready = !busy_q[c] || (cnt_q[c] == '0);
            end
        end
    end

    assign accept = hit & {CHANNELS{cmd_valid && cmd_ready}};

    always_comb begin
        pin_d  = pin_q;
        oe_d   = oe_q;
        busy_d = busy_q;
        done_d = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            mode_d[c]  = mode_q[c];
            shreg_d[c] = shreg_q[c];
            cnt_d[c]   = cnt_q[c];
            if (accept[c]) begin
                // The word finishing on this edge still reports completion.
                done_d[c] = (mode_q[c] == M_SHIFT) && busy_q[c] && (cnt_q[c] == '0);
                mode_d[c] = mode_t'(cmd_mode);
                busy_d[c] = 1'b0;
                cnt_d[c]  = '0;
                case (mode_t'(cmd_mode))
                    M_HOLD, M_TOGGLE: begin
                        pin_d[c] = cmd_data[0];
                        oe_d[c]  = 1'b1;
                    end
                    M_SHIFT: begin
                        pin_d[c]   = cmd_data[WIDTH-1];
                        oe_d[c]    = 1'b1;
                        shreg_d[c] = cmd_data;
                        cnt_d[c]   = NW'(WIDTH - 1);
                        busy_d[c]  = 1'b1;
                    end
                    default: begin
                        pin_d[c] = 1'b0;
                        oe_d[c]  = 1'b0;
                    end
                endcase
            end else begin
                case (mode_q[c])
                    M_TOGGLE: pin_d[c] = ~pin_q[c];
                    M_SHIFT: begin
                        if (busy_q[c]) begin
                            if (cnt_q[c] != '0) begin
                                shreg_d[c] = shreg_q[c] << 1;
                                pin_d[c]   = shreg_q[c][WIDTH-2];
                                cnt_d[c]   = cnt_q[c] - NW'(1);
                            end else begin
                                // Last bit already on the pin; it stays there under HOLD.
                                done_d[c] = 1'b1;
                                busy_d[c] = 1'b0;
                                mode_d[c] = M_HOLD;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pin_q  <= '0;
            oe_q   <= '0;
            busy_q <= '0;
            done_q <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                mode_q[c]  <= M_HIZ;
                shreg_q[c] <= '0;
                cnt_q[c]   <= '0;
            end
        end else begin
            pin_q  <= pin_d;
            oe_q   <= oe_d;
            busy_q <= busy_d;
            done_q <= done_d;
            for (int c = 0; c < CHANNELS; c++) begin
                mode_q[c]  <= mode_d[c];
                shreg_q[c] <= shreg_d[c];
                cnt_q[c]   <= cnt_d[c];
            end
        end
    end

    assign pin_out = pin_q;
    assign pin_oe  = oe_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule
